// File: rtl/updown_mod_counter.sv
// Parametrised synchronous up/down modulo counter with parallel load, wrap or saturate
// boundary handling, a one-cycle carry pulse and a sticky overflow flag.
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX      = 15,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (en) begin
      if (up) begin
        if (cnt_q == MaxVal) begin
          // Boundary event: wrap to 0 or stay pinned at MAX.
          cnt_d   = SATURATE ? MaxVal : '0;
          carry_d = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + One;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d   = SATURATE ? '0 : MaxVal;
          carry_d = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - One;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q      = cnt_q;
  assign carry  = carry_q;
  assign ovf    = ovf_q;
  assign at_max = (cnt_q == MaxVal);
  assign at_min = (cnt_q == '0);

  // The count must never leave the 0..MAX range.
  q_in_range_a : assert property (@(posedge clk) disable iff (rst) cnt_q <= MaxVal);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: a wrapping (MAX=9) and a saturating (MAX=15) instance share
// stimulus and are compared every cycle against an arithmetic reference model.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up;

  logic [3:0] w_q, s_q;
  logic       w_carry, w_ovf, w_at_max, w_at_min;
  logic       s_carry, s_ovf, s_at_max, s_at_min;

  int tests = 0;
  int fails = 0;

  // Reference state for each instance.
  int wq, sq;
  bit wc, wo, sc, so;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
    .q(w_q), .carry(w_carry), .ovf(w_ovf), .at_max(w_at_max), .at_min(w_at_min)
  );

  updown_mod_counter #(.WIDTH(4), .MAX(15), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
    .q(s_q), .carry(s_carry), .ovf(s_ovf), .at_max(s_at_max), .at_min(s_at_min)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("wrap_q", 32'(w_q), 32'(wq));
    check("wrap_carry", 32'(w_carry), 32'(wc));
    check("wrap_ovf", 32'(w_ovf), 32'(wo));
    check("wrap_at_max", 32'(w_at_max), 32'(wq == 9));
    check("wrap_at_min", 32'(w_at_min), 32'(wq == 0));
    check("sat_q", 32'(s_q), 32'(sq));
    check("sat_carry", 32'(s_carry), 32'(sc));
    check("sat_ovf", 32'(s_ovf), 32'(so));
    check("sat_at_max", 32'(s_at_max), 32'(sq == 15));
    check("sat_at_min", 32'(s_at_min), 32'(sq == 0));
  endtask

  // Modular arithmetic view of one rising edge.
  task automatic model_step(input int maxv, input bit sat, inout int qv, inout bit cv,
                            inout bit ov);
    cv = 1'b0;
    if (clr) begin
      qv = 0;
      ov = 1'b0;
    end else if (load) begin
      qv = (int'(load_val) > maxv) ? maxv : int'(load_val);
    end else if (en) begin
      int nxt = up ? qv + 1 : qv - 1;
      if (nxt < 0 || nxt > maxv) begin
        cv = 1'b1;
        ov = 1'b1;
        qv = sat ? qv : (nxt + maxv + 1) % (maxv + 1);
      end else begin
        qv = nxt;
      end
    end
  endtask

  task automatic model_reset();
    wq = 0; wc = 1'b0; wo = 1'b0;
    sq = 0; sc = 1'b0; so = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_step(9, 1'b0, wq, wc, wo);
      model_step(15, 1'b1, sq, sc, so);
    end
    #1;
    check_all();
  endtask

  task automatic set_in(input bit c, input bit l, input logic [3:0] lv, input bit e, input bit u);
    clr = c; load = l; load_val = lv; en = e; up = u;
  endtask

  // Reset pulse placed between clock edges.
  task automatic async_reset_pulse();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    #1;
    check_all();

    // Reset held for 3 edges with en high, then counting 1, 2, 3.
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // Up wrap from 0 across 10 edges.
    set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    repeat (10) tick();
    set_in(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    repeat (2) tick();

    // Down wrap, then immediate direction reversal.
    set_in(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    repeat (2) tick();
    up = 1'b1;
    tick();

    // Saturation at 15 (wrap instance sees a clamped load).
    set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b1, 4'd14, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    repeat (3) tick();
    set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    repeat (2) tick();

    // Load clamp, load beats en, clr beats load.
    set_in(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b1, 4'd4, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 1'b1, 4'd6, 1'b1, 1'b1);
    tick();

    // Asynchronous reset while the count sits at 7.
    set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    repeat (7) tick();
    async_reset_pulse();
    repeat (3) tick();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      clr      = ($urandom_range(31) == 0);
      load     = ($urandom_range(7) == 0);
      load_val = 4'($urandom);
      en       = ($urandom_range(3) != 0);
      up       = 1'($urandom);
      if ($urandom_range(63) == 0) begin
        async_reset_pulse();
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter. It is the next generation of the 4-bit ripple counter and replaces the T-flip-flop chain with a single-clock-domain register. It adds programmable width and modulus, parallel load, direction control, wrap or saturate mode, and carry/borrow reporting. It is intended as the general-purpose counter primitive for timers, dividers and address generators, and can be cascaded through `carry`.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits, minimum 1.
- `MAX`, default 15: terminal count. The counting range is 0..MAX, with MAX ≤ 2^WIDTH − 1.
- `SATURATE`, default 0: boundary behaviour. 0 means the counter wraps at a boundary; 1 means it holds at the boundary.

Ports:
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `clr`, input, 1: synchronous clear. Highest synchronous priority.
- `load`, input, 1: synchronous parallel load.
- `load_val`, input, WIDTH: value to load.
- `en`, input, 1: count enable.
- `up`, input, 1: direction. 1 counts up, 0 counts down.
- `q`, output, WIDTH: current count (registered).
- `carry`, output, 1: registered one-cycle pulse marking a boundary event.
- `ovf`, output, 1: sticky boundary-event flag (registered).
- `at_max`, output, 1: combinational decode of `q == MAX`.
- `at_min`, output, 1: combinational decode of `q == 0`.

## Operation
Reset:
- While `rst` is high, `q = 0`, `carry = 0` and `ovf = 0`, independent of `clk`.
- Deassertion is synchronised externally. The first count takes place on the first rising edge after `rst` falls.

Priority per rising edge is `clr` > `load` > `en` > hold:
- `clr`: `q ← 0`, `carry ← 0`, `ovf ← 0`.
- `load`:
  - If `load_val` ≤ MAX, `q ← load_val`.
  - Otherwise `q ← MAX` (the load value is clamped).
  - `carry ← 0` and `ovf` is unchanged.
- `en` with `up = 1`:
  - If `q < MAX`, `q ← q + 1`.
  - If `q == MAX`: `q ← 0` when SATURATE = 0, or `q` holds at MAX when SATURATE = 1. In both cases this is a boundary event.
- `en` with `up = 0`:
  - If `q > 0`, `q ← q − 1`.
  - If `q == 0`: `q ← MAX` when SATURATE = 0, or `q` holds at 0 when SATURATE = 1. In both cases this is a boundary event.
- No action (`en = 0`, no clear or load): `q` holds and `carry ← 0`.

Boundary events:
- On a boundary event, `carry ← 1` and `ovf ← 1`.
- On every other edge, `carry ← 0`.
- `ovf` is cleared only by `rst` or `clr`.
- In SATURATE mode, `carry` re-asserts on every enabled edge for as long as the counter is pinned at the boundary in the pushed direction.

Arithmetic and state:
- The next-state computation carries no overflow beyond WIDTH bits.
- The comparisons against MAX and 0 are unsigned.
- `q` must never hold a value greater than MAX. This invariant is checked by assertion.
- `up` may change on any cycle. A direction reversal takes effect on the same edge, with no dead cycle.

## Timing
- `q`, `carry` and `ovf` update on the rising `clk` edge, with one cycle of latency from `en`, `load` or `clr`.
- `carry` is high in exactly the cycle during which `q` shows the post-boundary value (for example, `q = 0` after a wrap from MAX).
- `at_max` and `at_min` follow `q` combinationally and have zero latency relative to `q`.
- Cascading: tie the `en` of the upper stage to `carry` of the lower stage. The upper stage then steps one cycle after the lower stage wraps. This is a documented skew.
- Reset in the middle of a count:
  - Asserting `rst` forces all registers to zero immediately, with no clock edge required.
  - A pending `load` or `en` on the same edge is discarded.
- Simultaneous `clr` and `load`: clear wins and `q = 0`.
- Simultaneous `load` and `en`: load wins and no count step is applied.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `en = 1` → `q = 0`, `carry = 0`, `ovf = 0` throughout, `at_min = 1`. After release with `up = 1`, `q` reads 1, 2, 3 on successive edges.
- **Up wrap (MAX = 9, SATURATE = 0):** count up from 0 for 10 edges → `q` steps 1..9 then 0. `carry` is high only in the cycle where `q = 0`, and `ovf` stays 1 afterwards.
- **Down wrap and direction change (MAX = 9):** load 1, set `up = 0`, en for 2 edges → `q` = 0, then 9 with `carry = 1`. Set `up = 1` → `q = 0` on the next edge, again with `carry = 1`.
- **Saturate (MAX = 15, SATURATE = 1):** load 14, `up = 1`, en for 3 edges → `q` = 15, 15, 15. `carry` is high on the 2nd and 3rd edges, and `ovf = 1`.
- **Load clamp and priority (MAX = 9):** `load_val = 12` → `q = 9`. Load together with `en` (`load_val = 4`) → `q = 4`. `clr` together with `load` → `q = 0` and `ovf = 0`.
- **Async reset mid-count:** pulse `rst` between clock edges while `q = 7` → `q = 0` before the next edge. There is no `carry` glitch, and counting resumes from 0.
